// File: rtl/popcount_pkg.sv
// popcount_pkg: shared constants, FSM state encoding and the half-adder cell
// used by the popcount sequencer and its nibble counter.
// No ports; import with "import popcount_pkg::*;".
package popcount_pkg;

  // Sequencer states, 2-bit encoded.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of one slice fed to the shared ones-counter.
  localparam int NIB_W = 4;

  // Width of the ones-counter result (0..4).
  localparam int PC_W = 3;

  // Half-adder cell output: carry and sum.
  typedef struct packed {
    logic c;
    logic s;
  } ha_t;

  function automatic ha_t half_add(input logic a, input logic b);
    ha_t r;
    r.s = a ^ b;
    r.c = a & b;
    return r;
  endfunction

endpackage

// File: rtl/nibble_popcount.sv
// nibble_popcount: combinational count of ones in a 4-bit slice, 0..4.
// Ports: nib_i [NIB_W-1:0] slice to count; cnt_o [PC_W-1:0] number of ones.
// Built from four half-adder cells; no state.
module nibble_popcount
  import popcount_pkg::*;
(
  input  logic [NIB_W-1:0] nib_i,
  output logic [PC_W-1:0]  cnt_o
);

  ha_t ha_lo;   // bits 0,1
  ha_t ha_hi;   // bits 2,3
  ha_t ha_sum;  // weight-1 sums combined
  ha_t ha_car;  // weight-2 carries combined

  assign ha_lo  = half_add(nib_i[0], nib_i[1]);
  assign ha_hi  = half_add(nib_i[2], nib_i[3]);
  assign ha_sum = half_add(ha_lo.s, ha_hi.s);
  assign ha_car = half_add(ha_lo.c, ha_hi.c);

  // ha_sum.c can only be set when both pair-sums are 1, which forces both
  // pair-carries to 0; so it never collides with ha_car.s and an OR is
  // enough for the weight-2 bit.
  assign cnt_o = {ha_car.c, ha_car.s | ha_sum.c, ha_sum.s};

endmodule

// File: rtl/popcount_sequencer.sv
// popcount_sequencer: counts the ones in a DATA_W-bit word by walking it one
// nibble per cycle (LSB first) through a single shared nibble_popcount.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data word input;
//        out_valid/out_ready/out_count result output; busy high in RUN/DONE.
// Optional macro POPCNT_SKIP_ZERO_EN: finish as soon as the remaining word is
// zero (data-dependent latency); otherwise latency is fixed at NIB+1 cycles.
module popcount_sequencer
  import popcount_pkg::*;
#(
  parameter  int DATA_W = 16,
  localparam int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              busy
);

  localparam int NIB   = DATA_W / NIB_W;
  // idx runs 0..NIB: one value per nibble plus the publish cycle.
  localparam int IDX_W = $clog2(NIB + 1);

  if ((DATA_W % NIB_W) != 0 || DATA_W < NIB_W) begin : g_bad_data_w
    $error("popcount_sequencer: DATA_W must be a multiple of 4 and at least 4");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  acc_q,   acc_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  logic [PC_W-1:0]   nib_cnt;
  logic              finish;

  nibble_popcount u_nibble_popcount (
    .nib_i (shreg_q[NIB_W-1:0]),
    .cnt_o (nib_cnt)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    finish  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          shreg_d = in_data;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // The last nibble is folded in while idx==NIB-1; the following cycle
        // (idx==NIB) copies the finished sum into the output register.
        if (idx_q == IDX_W'(NIB)) begin
          finish = 1'b1;
        end
`ifdef POPCNT_SKIP_ZERO_EN
        // Nothing left to count: acc is already the final answer.
        if (shreg_q == '0) begin
          finish = 1'b1;
        end
`endif
        if (finish) begin
          cnt_d   = acc_q;
          state_d = ST_DONE;
        end else begin
          acc_d   = acc_q + CNT_W'(nib_cnt);
          shreg_d = shreg_q >> NIB_W;
          idx_d   = idx_q + 1'b1;
        end
      end

      ST_DONE: begin
        // Result held until taken; in_ready stays low this cycle, so a new
        // word is only accepted from IDLE on the next one.
        if (out_ready) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      shreg_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Held low during reset so no word is accepted into an aborting block.
  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign out_count = cnt_q;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);

endmodule

// File: tb/tb_popcount_sequencer.sv
// tb_popcount_sequencer: directed and randomized checks of popcount_sequencer
// against a queue-based reference model (bit-loop popcount, nibble-scan latency).
// Build with POPCNT_SKIP_ZERO_EN defined to check the early-termination build.
module tb_popcount_sequencer;

  localparam int DATA_W = 16;
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int NIB    = DATA_W / 4;

`ifdef POPCNT_SKIP_ZERO_EN
  localparam int LAT_F0A5 = 5;
  localparam int LAT_0000 = 1;
  localparam int LAT_00F0 = 3;
`else
  localparam int LAT_F0A5 = 5;
  localparam int LAT_0000 = 5;
  localparam int LAT_00F0 = 5;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CNT_W-1:0]  out_count;
  logic              busy;

  popcount_sequencer #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model.
  function automatic int ref_pop(input logic [DATA_W-1:0] w);
    int c = 0;
    for (int i = 0; i < DATA_W; i++) c += int'(w[i]);
    return c;
  endfunction

  function automatic int ref_lat(input logic [DATA_W-1:0] w);
`ifdef POPCNT_SKIP_ZERO_EN
    int h = -1;
    for (int n = 0; n < NIB; n++)
      if (((w >> (4 * n)) & 16'hF) != 0) h = n;
    return h + 2;
`else
    return NIB + 1;
`endif
  endfunction

  // Scoreboard: words accepted but not yet delivered.
  int   cnt_q[$];
  int   lat_q[$];
  int   hs_q[$];
  logic mon_en   = 1'b0;
  logic ov_prev  = 1'b0;
  int   last_cnt = -1;
  int   last_lat = -1;
  int   n_in     = 0;
  int   n_out    = 0;

  always @(negedge clk) begin
    if (rst) begin
      cnt_q.delete();
      lat_q.delete();
      hs_q.delete();
      ov_prev = 1'b0;
    end else if (mon_en) begin
      chk("in_ready_is_not_busy", 32'(in_ready), 32'(!busy));
      if (!out_valid) chk("count_zero_outside_done", 32'(out_count), 0);
      if (out_valid) begin
        if (cnt_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 0);
        end else begin
          chk("out_count", 32'(out_count), cnt_q[0]);
          if (!ov_prev) begin
            last_lat = cyc - hs_q[0];
            chk("latency", last_lat, lat_q[0]);
          end
          if (out_ready) begin
            last_cnt = int'(out_count);
            n_out++;
            void'(cnt_q.pop_front());
            void'(lat_q.pop_front());
            void'(hs_q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        chk("one_word_in_flight", cnt_q.size(), 0);
        cnt_q.push_back(ref_pop(in_data));
        lat_q.push_back(ref_lat(in_data));
        hs_q.push_back(cyc + 1);
        n_in++;
      end
      ov_prev = out_valid;
    end
  end

  task automatic send(input logic [DATA_W-1:0] w);
    int t = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("send_ready_seen", 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int budget);
    int t = 0;
    while (!(out_valid && out_ready) && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    chk("out_handshake_seen", 32'(out_valid && out_ready), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_in, base_out, t;
    logic [DATA_W-1:0] w;

    // Reset, then idle.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_count", 32'(out_count), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 1);
    mon_en = 1'b1;

    // Single word with out_ready high.
    out_ready = 1'b1;
    send(16'hF0A5);
    chk("run_busy", 32'(busy), 1);
    chk("run_in_ready", 32'(in_ready), 0);
    wait_out(20);
    chk("f0a5_count", last_cnt, 8);
    chk("f0a5_latency", last_lat, LAT_F0A5);
    chk("f0a5_idle_in_ready", 32'(in_ready), 1);
    chk("f0a5_idle_out_valid", 32'(out_valid), 0);

    // Backpressure: result held while out_ready is low, junk input ignored.
    out_ready = 1'b0;
    send(16'hFFFF);
    t = 0;
    while (!out_valid && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b1;
    in_data  = 16'h1234;
    for (int k = 0; k < 10; k++) begin
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_out_count", 32'(out_count), 16);
      chk("bp_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    base_out  = n_out;
    @(posedge clk); #1;
    chk("bp_done_first_ready", n_out - base_out, 1);
    chk("bp_count", last_cnt, 16);
    chk("bp_after_out_valid", 32'(out_valid), 0);
    chk("bp_after_in_ready", 32'(in_ready), 1);

    // Back-to-back with in_valid held.
    base_out = n_out;
    in_data  = 16'h0001;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 16'h8000;
    t = 0;
    while (!in_ready && t < 30) begin
      @(posedge clk); #1;
      t++;
    end
    chk("b2b_first_result", n_out - base_out, 1);
    chk("b2b_first_count", last_cnt, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(20);
    chk("b2b_results", n_out - base_out, 2);
    chk("b2b_second_count", last_cnt, 1);

    // Reset in the middle of RUN aborts the word.
    base_out = n_out;
    send(16'hFFFF);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_out_valid", 32'(out_valid), 0);
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_result", n_out - base_out, 0);
    send(16'h000F);
    wait_out(20);
    chk("after_abort_count", last_cnt, 4);

    // Zero-heavy words (early termination when enabled).
    send(16'h0000);
    wait_out(20);
    chk("zero_count", last_cnt, 0);
    chk("zero_latency", last_lat, LAT_0000);
    send(16'h00F0);
    wait_out(20);
    chk("00f0_count", last_cnt, 4);
    chk("00f0_latency", last_lat, LAT_00F0);

    // Randomized traffic with random source gaps and sink stalls.
    base_in  = n_in;
    base_out = n_out;
    t = 0;
    while (n_out - base_out < 40 && t < 5000) begin
      w = DATA_W'($urandom);
      for (int n = 0; n < NIB; n++)
        if ($urandom_range(0, 2) == 0) w = w & ~(DATA_W'(16'hF) << (4 * n));
      in_data   = w;
      in_valid  = (n_in - base_in < 40) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 1) == 1);
      @(posedge clk); #1;
      t++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("rand_words_in", n_in - base_in, 40);
    chk("rand_words_out", n_out - base_out, 40);
    chk("rand_scoreboard_empty", cnt_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
